wb_bus_arbiter: RTL and testbench
=================================

WB_BUS_ARBITER -- requirements
Module: wb_bus_arbiter

Interface
REQ-001 Parameters SHALL be: HOLD_MAX, 4, maximum beats per grant before forced release (legal 1..15).
REQ-002 Ports SHALL be as follows.
- clk  in  1  system clock.
- rst  in  1  reset; reset is synchronous and active-low.
- req  in  4  bus requests: bit0 ALU, bit1 MM, bit2 IO, bit3 CC.
- last  in  4  final-beat flag per requester; sampled only for the current owner.
- gnt  out  4  one-hot grant, same bit order as req.
- owner  out  2  current or last owner code: 0 ALU, 1 MM, 2 IO, 3 CC.
- sel_alucc  out  1  final write-back mux select.
- sel_mmio  out  1  MM/IO mux select.
- sel_io  out  1  IO-memory/CC mux select.
- busy  out  1  high whenever state is not IDLE.
- abort  out  1  one-cycle pulse when the owner drops req before its last beat.

Function
REQ-003 The FSM SHALL have exactly three states: IDLE, GRANT and RELEASE.
REQ-004 IDLE transitions:
- any req bit set: go to GRANT with the round-robin winner.
- no req: remain in IDLE.
REQ-005 Arbitration latency SHALL be one cycle: req high at edge N gives gnt high from edge N+1.
REQ-006 Round-robin priority SHALL start at (previous owner + 1) mod 4 and search ascending, wrapping 3->0.
REQ-007 A beat SHALL occur on each GRANT cycle in which req[owner] is high.
REQ-008 GRANT SHALL count beats in a 4-bit counter that is cleared on entry to GRANT.
REQ-009 GRANT -> RELEASE SHALL occur on a beat where last[owner]=1 or where the beat count equals HOLD_MAX-1 (forced release).
REQ-010 GRANT -> RELEASE SHALL also occur when req[owner]=0 and last[owner]=0; abort SHALL pulse in the RELEASE cycle.
REQ-011 RELEASE SHALL be a single turnaround cycle with gnt=0.
REQ-012 RELEASE SHALL re-arbitrate: any req set goes to GRANT next cycle, otherwise to IDLE.
REQ-013 The owner just released SHALL have lowest priority in the RELEASE arbitration.
REQ-014 Mux selects SHALL decode from owner as follows:
- ALU: alucc=0, mmio=0, io=0.
- MM: alucc=1, mmio=0, io=0.
- IO: alucc=1, mmio=1, io=0.
- CC: alucc=1, mmio=1, io=1.
REQ-015 Selects SHALL hold their value through RELEASE and IDLE, so the bus never glitches between grants.
REQ-016 All outputs SHALL be registered; gnt SHALL be one-hot or zero in every cycle.
REQ-017 req changes of non-owners during GRANT SHALL be ignored until the next arbitration.
REQ-018 If last[owner] and the forced-release condition coincide, a single release SHALL occur with no abort.
REQ-019 HOLD_MAX=1 SHALL make every grant exactly one beat.

Reset
REQ-020 While rst=0 at a clock edge, the block SHALL reset to: state IDLE, gnt=0, owner=0, all selects 0, busy=0, abort=0, beat counter 0, round-robin pointer so that ALU wins first.
REQ-021 Reset asserted mid-GRANT SHALL drop gnt at that same edge; no abort pulse SHALL be generated.

Structure
REQ-022 Package wb_arb_pkg SHALL hold the state encoding, owner codes and select decode table as constants.
REQ-023 The round-robin search SHALL be a combinational sub-module rr_pick (inputs: req, pointer; output: winner code and valid).

Verification
REQ-024 The bench SHALL cover the following directed scenarios.
- Single request: req=0001 at cycle 1, last at beat 2 -> gnt=0001 cycles 2-3, RELEASE cycle 4, IDLE cycle 5, selects 000 throughout.
- Round-robin fairness: req=1111 held, last on every beat -> grant order ALU, MM, IO, CC, ALU, each separated by one RELEASE cycle.
- Forced release: HOLD_MAX=4, req=0100 held, last never set -> exactly 4 gnt cycles, RELEASE, then re-grant to IO; selects stay 110.
- Abort: MM owner drops req after 1 beat without last -> abort=1 for exactly one cycle, then MM is lowest priority versus pending CC.
- Reset mid-transfer: rst=0 during a CC grant -> next cycle gnt=0, owner=0, selects 000, busy=0, abort=0.
- Coincident last and forced release: last on beat HOLD_MAX -> one RELEASE cycle, abort=0.

Source files
------------

// File: rtl/wb_bus_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// wb_arb_pkg
// Shared constants for the write-back bus arbiter: FSM state encoding,
// requester/owner codes and the owner -> mux-select decode table.
// No ports (package).
// -----------------------------------------------------------------------------
package wb_arb_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_GRANT   = 2'd1,
    ST_RELEASE = 2'd2
  } state_t;

  localparam logic [1:0] OWN_ALU = 2'd0;
  localparam logic [1:0] OWN_MM  = 2'd1;
  localparam logic [1:0] OWN_IO  = 2'd2;
  localparam logic [1:0] OWN_CC  = 2'd3;

  // Each entry is {sel_alucc, sel_mmio, sel_io}, indexed by owner code.
  localparam logic [3:0][2:0] SEL_TABLE = {3'b111, 3'b110, 3'b100, 3'b000};

  function automatic logic [2:0] sel_decode(input logic [1:0] own);
    return SEL_TABLE[own];
  endfunction

endpackage

// File: rtl/wb_bus_arbiter_if.sv
// -----------------------------------------------------------------------------
// wb_bus_arbiter_if
// Bundles the requester-side handshake and the arbiter outputs.
//   req[3:0]   requests (bit0 ALU, bit1 MM, bit2 IO, bit3 CC)
//   last[3:0]  final-beat flag per requester
//   gnt[3:0]   one-hot grant
//   owner[1:0] current/last owner code
//   sel_*      write-back mux selects
//   busy       arbiter not idle
//   abort      owner dropped req before its last beat
// master: requester side; slave: arbiter side.
// -----------------------------------------------------------------------------
interface wb_bus_arbiter_if;
  logic [3:0] req;
  logic [3:0] last;
  logic [3:0] gnt;
  logic [1:0] owner;
  logic       sel_alucc;
  logic       sel_mmio;
  logic       sel_io;
  logic       busy;
  logic       abort;

  modport master (
    output req, last,
    input  gnt, owner, sel_alucc, sel_mmio, sel_io, busy, abort
  );

  modport slave (
    input  req, last,
    output gnt, owner, sel_alucc, sel_mmio, sel_io, busy, abort
  );
endinterface

// File: rtl/wb_bus_arbiter_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search: starting at i_ptr, scan ascending with
// wrap 3->0 and return the first requester found.
//   i_req[3:0]    request vector
//   i_ptr[1:0]    highest-priority index for this search
//   o_winner[1:0] winning requester code (i_ptr when nothing is requested)
//   o_valid       at least one request present
// -----------------------------------------------------------------------------
module rr_pick (
  input  logic [3:0] i_req,
  input  logic [1:0] i_ptr,
  output logic [1:0] o_winner,
  output logic       o_valid
);

  logic [1:0] w_idx;

  // Scan from the lowest priority offset upward so the highest priority
  // hit is the one left standing after the loop.
  always_comb begin
    o_winner = i_ptr;
    o_valid  = 1'b0;
    w_idx    = '0;
    for (int k = 3; k >= 0; k--) begin
      w_idx = i_ptr + 2'(k);
      if (i_req[w_idx]) begin
        o_winner = w_idx;
        o_valid  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/wb_bus_arbiter.sv
// -----------------------------------------------------------------------------
// wb_bus_arbiter
// Four-way round-robin arbiter for the final write-back bus. A grant lasts
// until the owner flags its last beat, hits HOLD_MAX beats, or drops its
// request (abort). Every grant is followed by one turnaround cycle.
//   clk   system clock
//   rst   synchronous, active-low reset
//   bus   wb_bus_arbiter_if.slave (req/last in; gnt/owner/selects/busy/abort out)
// Parameter HOLD_MAX: maximum beats per grant (1..15).
// -----------------------------------------------------------------------------
module wb_bus_arbiter
  import wb_arb_pkg::*;
#(
  parameter int HOLD_MAX = 4
) (
  input logic              clk,
  input logic              rst,
  wb_bus_arbiter_if.slave  bus
);

  localparam logic [3:0] HOLD_LIM = 4'(HOLD_MAX - 1);

  state_t     r_state, w_state_nxt;
  logic [1:0] r_owner, w_owner_nxt;
  logic [1:0] r_ptr,   w_ptr_nxt;
  logic [3:0] r_cnt,   w_cnt_nxt;
  logic [3:0] r_gnt,   w_gnt_nxt;
  logic [2:0] r_sel;
  logic       r_busy,  w_busy_nxt;
  logic       r_abort, w_abort_nxt;

  logic [1:0] w_win;
  logic       w_win_vld;
  logic       w_req_own;
  logic       w_last_own;
  logic       w_limit;

  assign w_req_own  = bus.req[r_owner];
  assign w_last_own = bus.last[r_owner];
  // r_cnt holds beats already taken, so this beat is number r_cnt+1.
  assign w_limit    = (r_cnt == HOLD_LIM);

  // The pointer always sits one past the latest owner, which also makes
  // the owner just released the lowest priority during RELEASE.
  rr_pick u_rr_pick (
    .i_req    (bus.req),
    .i_ptr    (r_ptr),
    .o_winner (w_win),
    .o_valid  (w_win_vld)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_owner_nxt = r_owner;
    w_ptr_nxt   = r_ptr;
    w_cnt_nxt   = r_cnt;
    w_abort_nxt = 1'b0;
    case (r_state)
      ST_IDLE, ST_RELEASE: begin
        if (w_win_vld) begin
          w_state_nxt = ST_GRANT;
          w_owner_nxt = w_win;
          w_ptr_nxt   = w_win + 2'd1;
          w_cnt_nxt   = 4'd0;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_GRANT: begin
        if (w_req_own) begin
          if (w_last_own || w_limit) begin
            w_state_nxt = ST_RELEASE;
          end else begin
            w_cnt_nxt = r_cnt + 4'd1;
          end
        end else begin
          // Owner withdrew; only an unflagged withdrawal is an abort.
          w_state_nxt = ST_RELEASE;
          w_abort_nxt = ~w_last_own;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    w_gnt_nxt  = (w_state_nxt == ST_GRANT) ? (4'b0001 << w_owner_nxt) : 4'b0000;
    w_busy_nxt = (w_state_nxt != ST_IDLE);
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Registered outputs and bookkeeping; selects follow the owner, which
  // only changes on a new grant, so they hold through RELEASE and IDLE.
  always_ff @(posedge clk) begin
    if (!rst) begin
      r_owner <= OWN_ALU;
      r_ptr   <= OWN_ALU;
      r_cnt   <= 4'd0;
      r_gnt   <= 4'd0;
      r_sel   <= 3'b000;
      r_busy  <= 1'b0;
      r_abort <= 1'b0;
    end else begin
      r_owner <= w_owner_nxt;
      r_ptr   <= w_ptr_nxt;
      r_cnt   <= w_cnt_nxt;
      r_gnt   <= w_gnt_nxt;
      r_sel   <= sel_decode(w_owner_nxt);
      r_busy  <= w_busy_nxt;
      r_abort <= w_abort_nxt;
    end
  end

  assign bus.gnt       = r_gnt;
  assign bus.owner     = r_owner;
  assign bus.sel_alucc = r_sel[2];
  assign bus.sel_mmio  = r_sel[1];
  assign bus.sel_io    = r_sel[0];
  assign bus.busy      = r_busy;
  assign bus.abort     = r_abort;

endmodule

// File: tb/tb_wb_bus_arbiter.sv
module tb_wb_bus_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic [3:0] last;

  always #5 clk = ~clk;

  wb_bus_arbiter_if bus0 ();
  wb_bus_arbiter_if bus1 ();

  assign bus0.req  = req;
  assign bus0.last = last;
  assign bus1.req  = req;
  assign bus1.last = last;

  wb_bus_arbiter #(.HOLD_MAX(4)) u_dut4 (.clk(clk), .rst(rst), .bus(bus0));
  wb_bus_arbiter #(.HOLD_MAX(1)) u_dut1 (.clk(clk), .rst(rst), .bus(bus1));

  // Packed view of all outputs: {gnt, owner, alucc, mmio, io, busy, abort}
  logic [10:0] act0, act1;
  assign act0 = {bus0.gnt, bus0.owner, bus0.sel_alucc, bus0.sel_mmio, bus0.sel_io,
                 bus0.busy, bus0.abort};
  assign act1 = {bus1.gnt, bus1.owner, bus1.sel_alucc, bus1.sel_mmio, bus1.sel_io,
                 bus1.busy, bus1.abort};

  int errors = 0;
  int checks = 0;

  // Reference model: 0 idle, 1 granted, 2 turnaround. One entry per DUT.
  int hold    [2] = '{4, 1};
  int m_st    [2];
  int m_own   [2];
  int m_start [2];
  int m_beats [2];
  bit m_abort [2];

  task automatic check(input string name, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, a, e, $time);
    end
  endtask

  function automatic logic [10:0] exp_of(input int i);
    logic [3:0] g;
    g = (m_st[i] == 1) ? 4'(1 << m_own[i]) : 4'd0;
    return {g, 2'(m_own[i]), (m_own[i] != 0), (m_own[i] >= 2), (m_own[i] == 3),
            (m_st[i] != 0), m_abort[i]};
  endfunction

  task automatic model_step(input logic r, input logic [3:0] q, input logic [3:0] l);
    for (int i = 0; i < 2; i++) begin
      if (!r) begin
        m_st[i] = 0; m_own[i] = 0; m_start[i] = 0; m_beats[i] = 0; m_abort[i] = 0;
      end else begin
        m_abort[i] = 0;
        if (m_st[i] != 1) begin
          int w;
          w = -1;
          for (int k = 0; k < 4; k++) begin
            int idx;
            idx = (m_start[i] + k) % 4;
            if (w < 0 && q[idx]) w = idx;
          end
          if (w >= 0) begin
            m_st[i] = 1; m_own[i] = w; m_start[i] = (w + 1) % 4; m_beats[i] = 0;
          end else begin
            m_st[i] = 0;
          end
        end else begin
          if (q[m_own[i]]) begin
            m_beats[i]++;
            if (l[m_own[i]] || m_beats[i] == hold[i]) m_st[i] = 2;
          end else begin
            m_st[i]    = 2;
            m_abort[i] = !l[m_own[i]];
          end
        end
      end
    end
  endtask

  task automatic step(input logic r, input logic [3:0] q, input logic [3:0] l);
    rst  = r;
    req  = q;
    last = l;
    @(posedge clk);
    model_step(r, q, l);
    #1;
    check("model_h4", 32'(act0), 32'(exp_of(0)));
    check("model_h1", 32'(act1), 32'(exp_of(1)));
  endtask

  typedef struct {
    logic        r;
    logic [3:0]  q;
    logic [3:0]  l;
    logic [10:0] e;
  } vec_t;

  vec_t tbl [13];
  int   rr_q [$];
  int   rr_exp [5] = '{0, 1, 2, 3, 0};
  int   run_len;
  bit   run_open;

  initial begin
    // {gnt, owner, sel(alucc,mmio,io), busy, abort}
    tbl[0]  = '{1'b0, 4'b0000, 4'b0000, {4'b0000, 2'd0, 3'b000, 1'b0, 1'b0}};
    tbl[1]  = '{1'b0, 4'b0000, 4'b0000, {4'b0000, 2'd0, 3'b000, 1'b0, 1'b0}};
    tbl[2]  = '{1'b1, 4'b0001, 4'b0000, {4'b0001, 2'd0, 3'b000, 1'b1, 1'b0}};
    tbl[3]  = '{1'b1, 4'b0001, 4'b0000, {4'b0001, 2'd0, 3'b000, 1'b1, 1'b0}};
    tbl[4]  = '{1'b1, 4'b0001, 4'b0001, {4'b0000, 2'd0, 3'b000, 1'b1, 1'b0}};
    tbl[5]  = '{1'b1, 4'b0000, 4'b0000, {4'b0000, 2'd0, 3'b000, 1'b0, 1'b0}};
    tbl[6]  = '{1'b1, 4'b0000, 4'b0000, {4'b0000, 2'd0, 3'b000, 1'b0, 1'b0}};
    tbl[7]  = '{1'b1, 4'b0100, 4'b0000, {4'b0100, 2'd2, 3'b110, 1'b1, 1'b0}};
    tbl[8]  = '{1'b1, 4'b0100, 4'b0000, {4'b0100, 2'd2, 3'b110, 1'b1, 1'b0}};
    tbl[9]  = '{1'b1, 4'b0100, 4'b0000, {4'b0100, 2'd2, 3'b110, 1'b1, 1'b0}};
    tbl[10] = '{1'b1, 4'b0100, 4'b0000, {4'b0100, 2'd2, 3'b110, 1'b1, 1'b0}};
    tbl[11] = '{1'b1, 4'b0100, 4'b0100, {4'b0000, 2'd2, 3'b110, 1'b1, 1'b0}};
    tbl[12] = '{1'b1, 4'b0000, 4'b0000, {4'b0000, 2'd2, 3'b110, 1'b0, 1'b0}};

    // Reset, single request, coincident last/forced release on beat 4
    for (int k = 0; k < 13; k++) begin
      step(tbl[k].r, tbl[k].q, tbl[k].l);
      check($sformatf("vec%0d", k), 32'(act0), 32'(tbl[k].e));
    end

    // Round-robin fairness with all requesting and last on every beat
    step(1'b0, 4'h0, 4'h0);
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 4'hF, 4'hF);
      if (bus0.gnt != 4'd0) rr_q.push_back(int'(bus0.owner));
      if (c % 2 == 1) check("rr_gap", 32'(bus0.gnt), 32'd0);
    end
    check("rr_count", rr_q.size(), 5);
    for (int k = 0; k < 5 && k < rr_q.size(); k++)
      check($sformatf("rr_order%0d", k), rr_q[k], rr_exp[k]);

    // Forced release: IO held, last never asserted
    step(1'b0, 4'h0, 4'h0);
    run_len  = 0;
    run_open = 1'b1;
    for (int c = 0; c < 10; c++) begin
      step(1'b1, 4'b0100, 4'b0000);
      check($sformatf("forced_gnt%0d", c), 32'(bus0.gnt),
            (c == 4 || c == 9) ? 32'd0 : 32'h4);
      check("forced_sel", 32'({bus0.sel_alucc, bus0.sel_mmio, bus0.sel_io}), 32'b110);
      check($sformatf("h1_gnt%0d", c), 32'(bus1.gnt), (c % 2 == 0) ? 32'h4 : 32'd0);
      if (run_open && bus0.gnt == 4'b0100) run_len++;
      else run_open = 1'b0;
    end
    check("forced_len", run_len, 4);

    // Abort: MM drops req after one beat while CC waits
    step(1'b0, 4'h0, 4'h0);
    step(1'b1, 4'b0010, 4'b0000);
    check("abort_grant_mm", 32'(bus0.gnt), 32'h2);
    step(1'b1, 4'b1010, 4'b0000);
    check("abort_hold_mm", 32'(bus0.gnt), 32'h2);
    step(1'b1, 4'b1000, 4'b0000);
    check("abort_pulse", 32'({bus0.abort, bus0.gnt, bus0.busy}), 32'b1_0000_1);
    step(1'b1, 4'b1010, 4'b0000);
    check("abort_cc_wins", 32'({bus0.abort, bus0.gnt, bus0.owner}), 32'b0_1000_11);
    step(1'b1, 4'b1010, 4'b0000);
    check("abort_once", 32'(bus0.abort), 32'd0);

    // Reset during the CC grant
    step(1'b0, 4'b1010, 4'b0000);
    check("reset_mid", 32'(act0), 32'd0);
    step(1'b1, 4'b0011, 4'b0000);
    check("reset_alu_first", 32'(bus0.gnt), 32'h1);

    // Randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      step(($urandom_range(0, 63) != 0), 4'($urandom | $urandom), 4'($urandom & $urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
